// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter control path.
package ram_arbiter_pkg;

  localparam int unsigned RD_LAT_DEF     = 1;
  localparam int unsigned MAX_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_READ_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  // Bits needed to hold values 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Winner selection between CPU and loader, with the CPU streak counter
// that forces a loader win after MAX_STREAK back-to-back CPU wins.
module ram_arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = MAX_STREAK_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_arb,
  input  logic   i_c_req,
  input  logic   i_d_req,
  output logic   o_win_c,
  output owner_e o_owner_c
);

  localparam int unsigned SW = cnt_width(MAX_STREAK + 1);

  logic [SW-1:0] r_streak;
  logic          w_at_max;

  assign w_at_max  = (r_streak == SW'(MAX_STREAK));
  assign o_win_c   = i_c_req | i_d_req;
  assign o_owner_c = (i_d_req && (!i_c_req || w_at_max)) ? OWN_LDR : OWN_CPU;

  // Streak tracks CPU wins taken while the loader was waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (i_arb) begin
      if (!i_d_req || (o_owner_c == OWN_LDR)) begin
        r_streak <= '0;
      end else if (!w_at_max) begin
        r_streak <= r_streak + SW'(1);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master (CPU / loader) arbiter in front of a single-port synchronous RAM.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned DW         = 16,
  parameter int unsigned AW         = 16,
  parameter int unsigned RD_LAT     = RD_LAT_DEF,
  parameter int unsigned MAX_STREAK = MAX_STREAK_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_en,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam int unsigned CW = cnt_width(RD_LAT);

  state_e        r_state, w_state_nxt;
  owner_e        r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_c_gnt, r_d_gnt, r_c_rvalid, r_d_rvalid, r_ram_en, r_ram_wr, r_busy;
  logic          w_c_gnt_nxt, w_d_gnt_nxt, w_c_rv_nxt, w_d_rv_nxt, w_en_nxt, w_wr_nxt;
  logic          w_rv_last, w_latch, w_arb, w_win_c;
  owner_e        w_owner_c;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  assign w_arb       = (r_state == ST_IDLE);
  assign w_sel_we    = (w_owner_c == OWN_LDR) ? d_we    : c_we;
  assign w_sel_addr  = (w_owner_c == OWN_LDR) ? d_addr  : c_addr;
  assign w_sel_wdata = (w_owner_c == OWN_LDR) ? d_wdata : c_wdata;

  ram_arb_pick #(
    .MAX_STREAK (MAX_STREAK)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .i_arb     (w_arb),
    .i_c_req   (c_req),
    .i_d_req   (d_req),
    .o_win_c   (w_win_c),
    .o_owner_c (w_owner_c)
  );

  // Next state plus next values of the registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_rv_last   = 1'b0;
    w_c_gnt_nxt = 1'b0;
    w_d_gnt_nxt = 1'b0;
    w_en_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_win_c) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_ACCESS;
          w_en_nxt    = 1'b1;
          w_wr_nxt    = w_sel_we;
          w_c_gnt_nxt = (w_owner_c == OWN_CPU);
          w_d_gnt_nxt = (w_owner_c == OWN_LDR);
        end
      end
      ST_ACCESS: begin
        if (r_we) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_READ_WAIT;
          w_cnt_nxt   = '0;
          w_rv_last   = (RD_LAT <= 1);
        end
      end
      ST_READ_WAIT: begin
        if (r_cnt == CW'(RD_LAT - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          w_rv_last = (w_cnt_nxt == CW'(RD_LAT - 1));
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_c_rv_nxt = w_rv_last && (r_owner == OWN_CPU);
    w_d_rv_nxt = w_rv_last && (r_owner == OWN_LDR);
  end

  // State, read-wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_c_gnt    <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_ram_en   <= 1'b0;
      r_ram_wr   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_c_gnt    <= w_c_gnt_nxt;
      r_d_gnt    <= w_d_gnt_nxt;
      r_c_rvalid <= w_c_rv_nxt;
      r_d_rvalid <= w_d_rv_nxt;
      r_ram_en   <= w_en_nxt;
      r_ram_wr   <= w_wr_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  // Winner's request is captured at the arbitration edge and held until the next win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= OWN_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_owner <= w_owner_c;
      r_we    <= w_sel_we;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end
  end

  assign c_gnt     = r_c_gnt;
  assign d_gnt     = r_d_gnt;
  assign c_rvalid  = r_c_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign ram_en    = r_ram_en;
  assign ram_wr    = r_ram_wr;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign busy      = r_busy;
  assign rdata     = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one instance with RD_LAT=1, one with RD_LAT=3,
// each with a behavioural RAM and a read-data scoreboard.
module tb_ram_arbiter;

  typedef struct packed {
    logic        ldr;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- instance 1 (RD_LAT = 1) ----------------
  logic        rst = 1'b1;
  logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [15:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, ram_en, ram_wr, busy;
  logic [15:0] rdata, ram_addr, ram_wdata, ram_rdata;

  ram_arbiter #(.DW(16), .AW(16), .RD_LAT(1), .MAX_STREAK(4)) u_dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .rdata(rdata), .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  logic [15:0] mem1 [0:1023];
  logic [15:0] p1;
  always @(posedge clk) begin
    if (ram_en && ram_wr) mem1[ram_addr[9:0]] <= ram_wdata;
    p1 <= mem1[ram_addr[9:0]];
  end
  assign ram_rdata = p1;

  // ---------------- instance 3 (RD_LAT = 3) ----------------
  logic        rst3 = 1'b1;
  logic        c_req3 = 0, c_we3 = 0, d_req3 = 0, d_we3 = 0;
  logic [15:0] c_addr3 = 0, c_wdata3 = 0, d_addr3 = 0, d_wdata3 = 0;
  logic        c_gnt3, c_rvalid3, d_gnt3, d_rvalid3, ram_en3, ram_wr3, busy3;
  logic [15:0] rdata3, ram_addr3, ram_wdata3, ram_rdata3;

  ram_arbiter #(.DW(16), .AW(16), .RD_LAT(3), .MAX_STREAK(4)) u_dut3 (
    .clk(clk), .rst(rst3),
    .c_req(c_req3), .c_we(c_we3), .c_addr(c_addr3), .c_wdata(c_wdata3),
    .c_gnt(c_gnt3), .c_rvalid(c_rvalid3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3),
    .rdata(rdata3), .ram_en(ram_en3), .ram_wr(ram_wr3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3), .busy(busy3)
  );

  logic [15:0] mem3 [0:1023];
  logic [15:0] p3a, p3b, p3c;
  always @(posedge clk) begin
    if (ram_en3 && ram_wr3) mem3[ram_addr3[9:0]] <= ram_wdata3;
    p3a <= mem3[ram_addr3[9:0]];
    p3b <= p3a;
    p3c <= p3b;
  end
  assign ram_rdata3 = p3c;

  // ---------------- scoreboards and loggers ----------------
  exp_t q1[$];
  exp_t q3[$];
  byte  glog[$];
  int   dbl = 0;
  int   wr_cnt = 0;
  string exp_s = "CCCCDCCCCD";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Read-data monitor, instance 1.
  always @(negedge clk) begin
    if (rst && (c_rvalid || d_rvalid)) begin
      exp_t e;
      total = total + 1;
      if (q1.size() == 0) begin
        bad = bad + 1;
        $display("FAIL rv1_unexpected c=%0b d=%0b rdata=%h", c_rvalid, d_rvalid, rdata);
      end else begin
        e = q1.pop_front();
        if ((c_rvalid && d_rvalid) || (d_rvalid != e.ldr) || (rdata !== e.data)) begin
          bad = bad + 1;
          $display("FAIL rv1_data c=%0b d=%0b rdata=%h want_ldr=%0b want=%h",
                   c_rvalid, d_rvalid, rdata, e.ldr, e.data);
        end
      end
    end
  end

  // Read-data monitor, instance 3.
  always @(negedge clk) begin
    if (rst3 && (c_rvalid3 || d_rvalid3)) begin
      exp_t e;
      total = total + 1;
      if (q3.size() == 0) begin
        bad = bad + 1;
        $display("FAIL rv3_unexpected c=%0b d=%0b rdata=%h", c_rvalid3, d_rvalid3, rdata3);
      end else begin
        e = q3.pop_front();
        if ((c_rvalid3 && d_rvalid3) || (d_rvalid3 != e.ldr) || (rdata3 !== e.data)) begin
          bad = bad + 1;
          $display("FAIL rv3_data c=%0b d=%0b rdata=%h want_ldr=%0b want=%h",
                   c_rvalid3, d_rvalid3, rdata3, e.ldr, e.data);
        end
      end
    end
  end

  // Grant order, grant exclusivity and write-strobe width on instance 1.
  always @(negedge clk) begin
    if (c_gnt && d_gnt) dbl = dbl + 1;
    if (c_gnt) glog.push_back(8'h43);
    if (d_gnt) glog.push_back(8'h44);
    if (ram_wr) wr_cnt = wr_cnt + 1;
  end

  task automatic settle1();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (busy && n < 40);
    chk("settle1_busy", busy, 0);
  endtask

  task automatic settle3();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (busy3 && n < 40);
    chk("settle3_busy", busy3, 0);
  endtask

  task automatic req1(input bit ldr, input bit we, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] exp_rd);
    int n = 0;
    if (ldr) begin d_we = we; d_addr = a; d_wdata = wd; d_req = 1; end
    else     begin c_we = we; c_addr = a; c_wdata = wd; c_req = 1; end
    if (!we) q1.push_back('{ldr: ldr, data: exp_rd});
    do begin @(posedge clk); #1; n++; end while (!(ldr ? d_gnt : c_gnt) && n < 40);
    chk(ldr ? "gnt1_d" : "gnt1_c", ldr ? d_gnt : c_gnt, 1);
    if (ldr) d_req = 0; else c_req = 0;
  endtask

  task automatic req3(input bit ldr, input bit we, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] exp_rd,
                      input bit push, output int gc);
    int n = 0;
    if (ldr) begin d_we3 = we; d_addr3 = a; d_wdata3 = wd; d_req3 = 1; end
    else     begin c_we3 = we; c_addr3 = a; c_wdata3 = wd; c_req3 = 1; end
    if (!we && push) q3.push_back('{ldr: ldr, data: exp_rd});
    do begin @(posedge clk); #1; n++; end while (!(ldr ? d_gnt3 : c_gnt3) && n < 40);
    chk(ldr ? "gnt3_d" : "gnt3_c", ldr ? d_gnt3 : c_gnt3, 1);
    gc = cyc;
    if (ldr) d_req3 = 0; else c_req3 = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc, rc, w, cnt, ng, n;

    // Reset: every output except rdata is low while rst is low.
    #2; rst = 1'b0; rst3 = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst3_busy", busy3, 0);
    @(negedge clk); rst = 1'b1; rst3 = 1'b1;
    @(posedge clk); #1;

    // Lone CPU read: gnt one cycle after the sampling edge, rvalid the next, idle after.
    req1(0, 1, 16'h0010, 16'hBEEF, 16'h0000);
    settle1();
    c_we = 0; c_addr = 16'h0010; c_req = 1;
    q1.push_back('{ldr: 1'b0, data: 16'hBEEF});
    @(posedge clk); #1;
    chk("r36_c_gnt", c_gnt, 1);
    chk("r36_d_gnt", d_gnt, 0);
    chk("r36_ram_en", ram_en, 1);
    chk("r36_ram_wr", ram_wr, 0);
    chk("r36_ram_addr", ram_addr, 16'h0010);
    c_req = 0;
    @(posedge clk); #1;
    chk("r36_c_rvalid", c_rvalid, 1);
    chk("r36_rdata", rdata, 16'hBEEF);
    chk("r36_ram_en_wait", ram_en, 0);
    @(posedge clk); #1;
    chk("r36_busy_off", busy, 0);
    chk("r36_rvalid_off", c_rvalid, 0);

    // Loader write then CPU read-back; the write strobe lasts one cycle.
    wr_cnt = 0;
    req1(1, 1, 16'h0200, 16'h1234, 16'h0000);
    settle1();
    chk("r37_wr_cycles", wr_cnt, 1);
    req1(0, 0, 16'h0200, 16'h0000, 16'h1234);
    settle1();

    // Both masters held: loader gets every fifth grant.
    glog.delete(); dbl = 0;
    c_we = 1; c_addr = 16'h0300; c_wdata = 16'h0001;
    d_we = 1; d_addr = 16'h0301; d_wdata = 16'h0002;
    c_req = 1; d_req = 1;
    ng = 0; n = 0;
    while (ng < 10 && n < 100) begin
      @(posedge clk); #1; n++;
      if (c_gnt || d_gnt) ng++;
    end
    c_req = 0; d_req = 0;
    @(negedge clk); #1;
    chk("streak_count", glog.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("streak_seq%0d", i), (i < glog.size()) ? glog[i] : 8'h2e, exp_s[i]);
    chk("gnt_exclusive", dbl, 0);
    settle1();
    chk("q1_empty", q1.size(), 0);

    // RD_LAT=3 loader read: rvalid lands in the third cycle after the gnt cycle, one cycle wide.
    req3(1, 1, 16'h0040, 16'hA5A5, 16'h0000, 1'b0, gc);
    settle3();
    req3(1, 0, 16'h0040, 16'h0000, 16'hA5A5, 1'b1, gc);
    rc = -1; w = 0;
    for (int i = 0; i < 6; i++) begin
      if (d_rvalid3) begin
        if (rc < 0) rc = cyc;
        w++;
      end
      @(posedge clk); #1;
    end
    chk("r40_latency", rc - gc, 3);
    chk("r40_width", w, 1);
    settle3();

    // Request raised and dropped within one IDLE cycle never gets a grant.
    d_we3 = 0; d_addr3 = 16'h0040; d_req3 = 1;
    @(negedge clk); d_req3 = 0;
    ng = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (d_gnt3 || busy3) ng++;
    end
    chk("r40_drop_no_gnt", ng, 0);

    // Reset in READ_WAIT aborts the read; the next request is served normally.
    req3(0, 0, 16'h0040, 16'h0000, 16'h0000, 1'b0, gc);
    @(posedge clk); #1;
    chk("r39_busy_in_wait", busy3, 1);
    rst3 = 1'b0;
    #1;
    chk("r39_busy_reset", busy3, 0);
    chk("r39_rvalid_reset", c_rvalid3, 0);
    @(negedge clk); rst3 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (c_rvalid3) cnt++;
    end
    chk("r39_no_rvalid", cnt, 0);
    req3(0, 0, 16'h0040, 16'h0000, 16'hA5A5, 1'b1, gc);
    settle3();
    chk("q3_empty", q3.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
